backprop_sequencer: RTL and testbench
=====================================

Name: backprop_sequencer

Overview:
- Training-loop controller for the single-hidden-node network.
- Per training sample it:
  - requests a forward pass;
  - waits for its completion;
  - pulses the backprop weight-update enable for exactly one cycle;
  - advances sample and epoch counters.
- Sits between the top-level command interface and the forward datapath / hidden_backprop weight-update stage.
- Also issues the one-cycle zero-weight clear at the start of every run and aborts on a forward-pass watchdog timeout.

Parameters:
- NUM_SAMPLES, 4: training samples per epoch (>=2); SW = $clog2(NUM_SAMPLES).
- EPOCHS, 8: epochs per run (>=1); EW = $clog2(EPOCHS+1).
- FWD_TIMEOUT, 15: max cycles in FWD_WAIT with fwd_done_i low before error (>=1).

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin run; honoured only in IDLE, DONE, ERR.
- abort_i  in  1  return to IDLE from any state.
- fwd_done_i  in  1  forward pass complete; sampled only in FWD_WAIT.
- b_end_i  in  1  end flag from backprop stage; sampled only in BACKPROP.
- fwd_start_o  out  1  one-cycle forward-pass request.
- bp_en_o  out  1  one-cycle weight-update enable (drives en_i of the update stage).
- zero_weight_reset_o  out  1  one-cycle weight clear.
- sample_idx_o  out  SW  current sample index.
- epoch_o  out  EW  completed epochs in current run.
- b_end_cnt_o  out  8  count of b_end_i=1 seen in BACKPROP this run, saturating at 255.
- busy_o  out  1  high in every state except IDLE, DONE, ERR.
- done_o  out  1  high in DONE.
- timeout_o  out  1  high in ERR.

Behaviour:
- Reset (async, rst_i=0): state IDLE; all pulses 0; sample_idx_o, epoch_o, b_end_cnt_o, watchdog = 0; busy_o, done_o, timeout_o = 0.
- All outputs are Moore (registered state decode); no combinational input-to-output path.
- IDLE: start_i=1 -> CLEAR; counters zeroed on the same edge.
- CLEAR: zero_weight_reset_o=1 -> FWD_REQ.
- FWD_REQ: fwd_start_o=1; watchdog cleared -> FWD_WAIT.
- FWD_WAIT:
  - fwd_done_i=1 -> BACKPROP;
  - else if watchdog==FWD_TIMEOUT-1 -> ERR;
  - else watchdog++.
  - Net effect: exactly FWD_TIMEOUT low cycles produce ERR. Done in the last permitted cycle wins over timeout.
- BACKPROP: bp_en_o=1; if b_end_i=1, b_end_cnt_o++ (saturating) -> ADVANCE.
- ADVANCE:
  - if sample_idx_o==NUM_SAMPLES-1: sample_idx_o<=0, epoch_o++; next is DONE if the new epoch==EPOCHS, else FWD_REQ.
  - else sample_idx_o++ -> FWD_REQ.
- DONE: done_o held; counters held for readout; start_i -> CLEAR (fresh run).
- ERR: timeout_o held; counters held; start_i -> CLEAR.
- Latency:
  - start_i at edge 0 -> zero_weight_reset_o at cycle 1, fwd_start_o at cycle 2.
  - fwd_done_i at cycle k -> bp_en_o at k+1, next fwd_start_o at k+3.
- Priority: abort_i > start_i > all other inputs. abort_i with fwd_done_i in the same cycle goes to IDLE; no bp_en_o pulse.
- abort_i in IDLE: no effect. After abort, counters are zeroed on entry to IDLE. A pulse is never cut short (one-cycle states).
- start_i while busy_o=1: ignored. fwd_done_i outside FWD_WAIT: ignored (no latching). b_end_i outside BACKPROP: ignored.
- Reset asserted mid-run: immediate return to IDLE values; no pulse is emitted on reset release.

Decomposition:
- Package nn_ctrl_pkg holds:
  - state enum: IDLE, CLEAR, FWD_REQ, FWD_WAIT, BACKPROP, ADVANCE, DONE, ERR;
  - width helper constants SW and EW;
  - saturation limit 8'hFF.
- Sub-module fwd_watchdog: clear/enable inputs, FWD_TIMEOUT parameter, expire output. Instantiated once.

Test Plan:
- NUM_SAMPLES=4, EPOCHS=2, fwd_done_i 3 cycles after each fwd_start_o:
  - 1 zero_weight_reset_o, 8 fwd_start_o, 8 bp_en_o;
  - sample_idx_o sequence 0,1,2,3,0,1,2,3;
  - done_o=1, epoch_o=2, busy_o=0.
- b_end_i=1 during BACKPROP on samples 1 and 3 of both epochs, and b_end_i=1 outside BACKPROP -> b_end_cnt_o=4 at DONE.
- FWD_TIMEOUT=15:
  - fwd_done_i never returned -> ERR exactly 15 cycles after entering FWD_WAIT, timeout_o=1, no bp_en_o.
  - fwd_done_i on the 15th cycle -> BACKPROP, no ERR.
- abort_i together with fwd_done_i in FWD_WAIT -> IDLE next cycle, bp_en_o stays 0, counters 0. start_i while busy -> no restart.
- rst_i low for 1 cycle mid-epoch 1 (asynchronous, between clock edges) -> all outputs 0 immediately. Then start_i -> zero_weight_reset_o pulse at cycle 1.
- From DONE and from ERR, start_i -> fresh run with counters zeroed and a zero_weight_reset_o pulse.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg
// Shared definitions for the single-hidden-node training controller:
//   - state_e     : training-loop sequencer states
//   - sw_of/ew_of : width helpers for the sample index and epoch counter
//   - B_END_SAT   : saturation limit of the backprop end-flag counter
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        FWD_REQ  = 3'd2,
        FWD_WAIT = 3'd3,
        BACKPROP = 3'd4,
        ADVANCE  = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_e;

    // Sample index width: enough bits for 0 .. num_samples-1 (num_samples >= 2).
    function automatic int sw_of(input int num_samples);
        return $clog2(num_samples);
    endfunction

    // Epoch counter width: must also hold the terminal value `epochs`.
    function automatic int ew_of(input int epochs);
        return $clog2(epochs + 1);
    endfunction

    localparam logic [7:0] B_END_SAT = 8'hFF;

endpackage

// File: rtl/fwd_watchdog.sv
// fwd_watchdog
// Counts cycles spent waiting for a forward pass. The count is cleared by
// clear_i and advanced by en_i; expire_o flags the last permitted cycle so
// the sequencer can choose between timing out and accepting a late done.
// Ports:
//   clk_i     in   clock
//   rst_i     in   asynchronous active-low reset
//   clear_i   in   zero the count
//   en_i      in   advance the count by one
//   expire_o  out  count has reached FWD_TIMEOUT-1
module fwd_watchdog #(
    parameter int FWD_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (FWD_TIMEOUT < 2) ? 1 : $clog2(FWD_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(FWD_TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter; stops at LAST so it never wraps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {CW{1'b0}};
        end else if (en_i && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire_o = (cnt_r == LAST);

endmodule

// File: rtl/backprop_sequencer.sv
// backprop_sequencer
// Training-loop controller: per sample it requests a forward pass, waits for
// it (guarded by a watchdog), pulses the weight-update enable for one cycle
// and advances the sample/epoch counters. Every run starts with a one-cycle
// weight clear. All outputs are flops loaded from the next-state decode, so
// there is no combinational input-to-output path.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   start_i               begin run (IDLE/DONE/ERR only)
//   abort_i               return to IDLE from any state
//   fwd_done_i            forward pass complete (FWD_WAIT only)
//   b_end_i               backprop end flag (BACKPROP only)
//   fwd_start_o           one-cycle forward-pass request
//   bp_en_o               one-cycle weight-update enable
//   zero_weight_reset_o   one-cycle weight clear
//   sample_idx_o          current sample index
//   epoch_o               completed epochs this run
//   b_end_cnt_o           saturating count of b_end_i seen in BACKPROP
//   busy_o, done_o, timeout_o  status
module backprop_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int EPOCHS      = 8,
    parameter int FWD_TIMEOUT = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           fwd_done_i,
    input  logic                           b_end_i,
    output logic                           fwd_start_o,
    output logic                           bp_en_o,
    output logic                           zero_weight_reset_o,
    output logic [sw_of(NUM_SAMPLES)-1:0]  sample_idx_o,
    output logic [ew_of(EPOCHS)-1:0]       epoch_o,
    output logic [7:0]                     b_end_cnt_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           timeout_o
);

    localparam int SAMP_W  = sw_of(NUM_SAMPLES);
    localparam int EPOCH_W = ew_of(EPOCHS);

    state_e              state_r, state_next_s;
    logic [SAMP_W-1:0]   sample_idx_r, sample_next_s;
    logic [EPOCH_W-1:0]  epoch_r, epoch_next_s, epoch_inc_s;
    logic [7:0]          b_end_cnt_r, b_end_cnt_next_s;
    logic                wd_clear_s, wd_en_s, wd_expire_s;
    logic                fwd_start_r, bp_en_r, zwr_r, busy_r, done_r, timeout_r;

    fwd_watchdog #(
        .FWD_TIMEOUT (FWD_TIMEOUT)
    ) u_fwd_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (wd_clear_s),
        .en_i     (wd_en_s),
        .expire_o (wd_expire_s)
    );

    // Next-state, counter next values and watchdog controls.
    always_comb begin
        state_next_s     = state_r;
        sample_next_s    = sample_idx_r;
        epoch_next_s     = epoch_r;
        b_end_cnt_next_s = b_end_cnt_r;
        wd_clear_s       = 1'b0;
        wd_en_s          = 1'b0;
        epoch_inc_s      = epoch_r + EPOCH_W'(1'b1);

        if (abort_i && (state_r != IDLE)) begin
            // Abort outranks everything, including a coincident fwd_done_i.
            state_next_s     = IDLE;
            sample_next_s    = {SAMP_W{1'b0}};
            epoch_next_s     = {EPOCH_W{1'b0}};
            b_end_cnt_next_s = 8'h00;
        end else if (start_i && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR))) begin
            state_next_s     = CLEAR;
            sample_next_s    = {SAMP_W{1'b0}};
            epoch_next_s     = {EPOCH_W{1'b0}};
            b_end_cnt_next_s = 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = IDLE;
                end
                CLEAR: begin
                    state_next_s = FWD_REQ;
                end
                FWD_REQ: begin
                    wd_clear_s   = 1'b1;
                    state_next_s = FWD_WAIT;
                end
                FWD_WAIT: begin
                    // A done in the last permitted cycle beats the timeout.
                    if (fwd_done_i) begin
                        state_next_s = BACKPROP;
                    end else if (wd_expire_s) begin
                        state_next_s = ERR;
                    end else begin
                        wd_en_s = 1'b1;
                    end
                end
                BACKPROP: begin
                    if (b_end_i && (b_end_cnt_r != B_END_SAT)) begin
                        b_end_cnt_next_s = b_end_cnt_r + 8'h01;
                    end else begin
                        b_end_cnt_next_s = b_end_cnt_r;
                    end
                    state_next_s = ADVANCE;
                end
                ADVANCE: begin
                    if (sample_idx_r == SAMP_W'(NUM_SAMPLES - 1)) begin
                        sample_next_s = {SAMP_W{1'b0}};
                        epoch_next_s  = epoch_inc_s;
                        if (epoch_inc_s == EPOCH_W'(EPOCHS)) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = FWD_REQ;
                        end
                    end else begin
                        sample_next_s = sample_idx_r + SAMP_W'(1'b1);
                        state_next_s  = FWD_REQ;
                    end
                end
                DONE: begin
                    state_next_s = DONE;
                end
                ERR: begin
                    state_next_s = ERR;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters and registered output decode of the upcoming state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sample_idx_r <= {SAMP_W{1'b0}};
            epoch_r      <= {EPOCH_W{1'b0}};
            b_end_cnt_r  <= 8'h00;
            fwd_start_r  <= 1'b0;
            bp_en_r      <= 1'b0;
            zwr_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            sample_idx_r <= sample_next_s;
            epoch_r      <= epoch_next_s;
            b_end_cnt_r  <= b_end_cnt_next_s;
            fwd_start_r  <= (state_next_s == FWD_REQ);
            bp_en_r      <= (state_next_s == BACKPROP);
            zwr_r        <= (state_next_s == CLEAR);
            busy_r       <= !((state_next_s == IDLE) || (state_next_s == DONE) || (state_next_s == ERR));
            done_r       <= (state_next_s == DONE);
            timeout_r    <= (state_next_s == ERR);
        end
    end

    assign fwd_start_o         = fwd_start_r;
    assign bp_en_o             = bp_en_r;
    assign zero_weight_reset_o = zwr_r;
    assign sample_idx_o        = sample_idx_r;
    assign epoch_o             = epoch_r;
    assign b_end_cnt_o         = b_end_cnt_r;
    assign busy_o              = busy_r;
    assign done_o              = done_r;
    assign timeout_o           = timeout_r;

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb_backprop_sequencer
// Directed scenarios for backprop_sequencer with NUM_SAMPLES=4, EPOCHS=2,
// FWD_TIMEOUT=15. A small responder returns fwd_done_i a fixed delay after
// each fwd_start_o; expected sample indices are queued when a run is started
// and popped on every bp_en_o pulse.
module tb_backprop_sequencer;

    localparam int NS = 4;
    localparam int EP = 2;
    localparam int TO = 15;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, abort_i, fwd_done_i, b_end_i;
    logic       fwd_start_o, bp_en_o, zero_weight_reset_o;
    logic [1:0] sample_idx_o;
    logic [1:0] epoch_o;
    logic [7:0] b_end_cnt_o;
    logic       busy_o, done_o, timeout_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cd       = 0;
    logic done_driven = 1'b0;
    int   sb[$];

    backprop_sequencer #(
        .NUM_SAMPLES (NS),
        .EPOCHS      (EP),
        .FWD_TIMEOUT (TO)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .fwd_done_i          (fwd_done_i),
        .b_end_i             (b_end_i),
        .fwd_start_o         (fwd_start_o),
        .bp_en_o             (bp_en_o),
        .zero_weight_reset_o (zero_weight_reset_o),
        .sample_idx_o        (sample_idx_o),
        .epoch_o             (epoch_o),
        .b_end_cnt_o         (b_end_cnt_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .timeout_o           (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One cycle plus forward-pass responder: fwd_done_i goes high three
    // cycles after each observed fwd_start_o, for one cycle.
    task automatic tick_resp();
        tick();
        fwd_done_i  = 1'b0;
        done_driven = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                fwd_done_i  = 1'b1;
                done_driven = 1'b1;
            end
        end
        if (fwd_start_o) cd = 3;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; fwd_done_i = 1'b0; b_end_i = 1'b0;
        #2;
        n_checks++; if ({fwd_start_o, bp_en_o, zero_weight_reset_o} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {fwd_start_o, bp_en_o, zero_weight_reset_o}); end
        n_checks++; if ({sample_idx_o, epoch_o, b_end_cnt_o} !== 12'h000) begin n_fail++; $display("FAIL reset_counters: got %h want 000", {sample_idx_o, epoch_o, b_end_cnt_o}); end
        n_checks++; if ({busy_o, done_o, timeout_o} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy_o, done_o, timeout_o}); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        n_checks++; if ({busy_o, fwd_start_o, zero_weight_reset_o} !== 3'b000) begin n_fail++; $display("FAIL idle_after_release: got %b want 000", {busy_o, fwd_start_o, zero_weight_reset_o}); end
    endtask

    task automatic test_full_run();
        int  cnt_z, cnt_f, cnt_b, cyc, exp_s;
        logic prev_done;
        for (int e = 0; e < EP; e++) for (int s = 0; s < NS; s++) sb.push_back(s);
        cd = 0;
        start_i = 1'b1;
        tick_resp();
        start_i = 1'b0;
        n_checks++; if (zero_weight_reset_o !== 1'b1) begin n_fail++; $display("FAIL run_zwr_cycle1: got %b want 1", zero_weight_reset_o); end
        tick_resp();
        n_checks++; if (fwd_start_o !== 1'b1) begin n_fail++; $display("FAIL run_fwd_cycle2: got %b want 1", fwd_start_o); end
        cnt_z = 1; cnt_f = 1; cnt_b = 0; cyc = 0;
        while (!done_o && cyc < 200) begin
            prev_done = done_driven;
            tick_resp();
            cyc++;
            if (zero_weight_reset_o) cnt_z++;
            if (fwd_start_o) cnt_f++;
            if (prev_done) begin
                n_checks++; if (bp_en_o !== 1'b1) begin n_fail++; $display("FAIL bp_latency: got %b want 1 (cycle %0d)", bp_en_o, cyc); end
            end
            if (bp_en_o) begin
                cnt_b++;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL sb_underflow: got extra bp_en_o want none");
                end else begin
                    exp_s = sb.pop_front();
                    n_checks++; if (sample_idx_o !== 2'(exp_s)) begin n_fail++; $display("FAIL sample_idx: got %0d want %0d", sample_idx_o, exp_s); end
                end
            end
            b_end_i = 1'b0;
            if (prev_done) b_end_i = ((((cnt_f - 1) % NS) == 1) || (((cnt_f - 1) % NS) == 3));
            else if (cd == 1) b_end_i = 1'b1;
        end
        b_end_i = 1'b0; fwd_done_i = 1'b0; cd = 0;
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b want 1", done_o); end
        n_checks++; if (epoch_o !== 2'd2) begin n_fail++; $display("FAIL run_epoch: got %0d want 2", epoch_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL run_busy: got %b want 0", busy_o); end
        n_checks++; if (cnt_z !== 1) begin n_fail++; $display("FAIL run_zwr_count: got %0d want 1", cnt_z); end
        n_checks++; if (cnt_f !== 8) begin n_fail++; $display("FAIL run_fwd_count: got %0d want 8", cnt_f); end
        n_checks++; if (cnt_b !== 8) begin n_fail++; $display("FAIL run_bp_count: got %0d want 8", cnt_b); end
        n_checks++; if (b_end_cnt_o !== 8'd4) begin n_fail++; $display("FAIL run_b_end_cnt: got %0d want 4", b_end_cnt_o); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_timeout_from_done();
        int   n;
        logic bp_seen;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if (zero_weight_reset_o !== 1'b1) begin n_fail++; $display("FAIL done_restart_zwr: got %b want 1", zero_weight_reset_o); end
        n_checks++; if ({done_o, epoch_o, sample_idx_o, b_end_cnt_o} !== 13'h0) begin n_fail++; $display("FAIL done_restart_counters: got %h want 0", {done_o, epoch_o, sample_idx_o, b_end_cnt_o}); end
        tick();
        n_checks++; if (fwd_start_o !== 1'b1) begin n_fail++; $display("FAIL to_fwd_start: got %b want 1", fwd_start_o); end
        n = 0; bp_seen = 1'b0;
        while (!timeout_o && n < 40) begin
            tick();
            n++;
            if (bp_en_o) bp_seen = 1'b1;
        end
        n_checks++; if (n !== TO + 1) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
        n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", timeout_o); end
        n_checks++; if ({bp_seen, busy_o} !== 2'b00) begin n_fail++; $display("FAIL to_no_bp_not_busy: got %b want 00", {bp_seen, busy_o}); end
    endtask

    task automatic test_done_last_cycle();
        logic to_seen;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if ({zero_weight_reset_o, timeout_o} !== 2'b10) begin n_fail++; $display("FAIL err_restart: got %b want 10", {zero_weight_reset_o, timeout_o}); end
        tick();
        to_seen = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (timeout_o) to_seen = 1'b1;
            if (i == TO) fwd_done_i = 1'b1;
        end
        tick();
        fwd_done_i = 1'b0;
        n_checks++; if (bp_en_o !== 1'b1) begin n_fail++; $display("FAIL late_done_bp: got %b want 1", bp_en_o); end
        n_checks++; if ({to_seen, timeout_o} !== 2'b00) begin n_fail++; $display("FAIL late_done_no_err: got %b want 00", {to_seen, timeout_o}); end
        tick();
        tick();
        n_checks++; if ({fwd_start_o, sample_idx_o} !== 3'b101) begin n_fail++; $display("FAIL late_done_next: got %b want 101", {fwd_start_o, sample_idx_o}); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    task automatic test_abort();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        fwd_done_i = 1'b1;
        tick();
        fwd_done_i = 1'b0;
        n_checks++; if (bp_en_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre_bp: got %b want 1", bp_en_o); end
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if ({fwd_start_o, zero_weight_reset_o, sample_idx_o} !== 4'b1001) begin n_fail++; $display("FAIL start_while_busy: got %b want 1001", {fwd_start_o, zero_weight_reset_o, sample_idx_o}); end
        tick();
        abort_i = 1'b1; fwd_done_i = 1'b1;
        tick();
        abort_i = 1'b0; fwd_done_i = 1'b0;
        n_checks++; if ({busy_o, bp_en_o} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got %b want 00", {busy_o, bp_en_o}); end
        n_checks++; if ({sample_idx_o, epoch_o, b_end_cnt_o} !== 12'h000) begin n_fail++; $display("FAIL abort_counters: got %h want 000", {sample_idx_o, epoch_o, b_end_cnt_o}); end
        tick();
        n_checks++; if (bp_en_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_bp: got %b want 0", bp_en_o); end
    endtask

    task automatic test_async_reset();
        int cyc;
        cd = 0;
        start_i = 1'b1;
        tick_resp();
        start_i = 1'b0;
        cyc = 0;
        while (!(epoch_o == 2'd1 && sample_idx_o == 2'd1) && cyc < 200) begin
            tick_resp();
            cyc++;
        end
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL reach_epoch1: got budget expiry want epoch 1 sample 1"); end
        #3;
        rst_i = 1'b0;
        fwd_done_i = 1'b0; cd = 0;
        #1;
        n_checks++; if ({fwd_start_o, bp_en_o, zero_weight_reset_o, busy_o, done_o, timeout_o} !== 6'b0) begin n_fail++; $display("FAIL async_rst_flags: got %b want 000000", {fwd_start_o, bp_en_o, zero_weight_reset_o, busy_o, done_o, timeout_o}); end
        n_checks++; if ({sample_idx_o, epoch_o, b_end_cnt_o} !== 12'h000) begin n_fail++; $display("FAIL async_rst_counters: got %h want 000", {sample_idx_o, epoch_o, b_end_cnt_o}); end
        @(posedge clk_i);
        #4;
        rst_i = 1'b1;
        tick();
        n_checks++; if ({fwd_start_o, bp_en_o, zero_weight_reset_o, busy_o} !== 4'b0) begin n_fail++; $display("FAIL rst_release_quiet: got %b want 0000", {fwd_start_o, bp_en_o, zero_weight_reset_o, busy_o}); end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if (zero_weight_reset_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_zwr: got %b want 1", zero_weight_reset_o); end
        tick();
        n_checks++; if (fwd_start_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_fwd: got %b want 1", fwd_start_o); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_timeout_from_done();
        test_done_last_cycle();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
